instr_mem_sync: RTL and testbench
=================================

// Module: instr_mem_sync
// PURPOSE
//  Parametrised, synchronous, writable instruction memory for the single-cycle/pipelined LEGv8 core.
//  Replaces the hard-coded combinational program store.
//  The fetch stage reads through a pipelined request/valid port; the testbench/loader writes programs through a write port.
//  After reset an INIT sequencer fills every word with DEFAULT_WORD (BR XZR), so unprogrammed or out-of-range fetches halt safely.
// PARAMETERS
//  DATA_W       32            instruction word width
//  ADDR_W       16            word-index address width (address = instruction index, not byte address)
//  DEPTH        64            number of implemented words; DEPTH <= 2**ADDR_W, DEPTH >= 2
//  DEFAULT_WORD 32'hD60003E0  fill / out-of-range value (BR XZR)
//  READ_LAT     1             read latency in cycles; legal values 1 or 2
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  rd_en      in   1       fetch request; accepted when rd_ready=1
//  rd_addr    in   ADDR_W  fetch word index
//  rd_ready   out  1       high when not in INIT
//  rd_valid   out  1       rd_data holds the result of an accepted request
//  rd_data    out  DATA_W  fetched word
//  wr_en      in   1       program write; accepted when rd_ready=1
//  wr_addr    in   ADDR_W  write word index
//  wr_data    in   DATA_W  write data
//  wr_err     out  1       1-cycle pulse: accepted write had wr_addr >= DEPTH (write discarded)
//  init_busy  out  1       high while the INIT fill is in progress
// BEHAVIOUR
//  Reset (async assert, any state, mid-operation included):
//   - state=INIT, fill counter=0, read pipeline flushed.
//   - rd_valid=0, rd_data=DEFAULT_WORD, wr_err=0, init_busy=1, rd_ready=0.
//  FSM INIT:
//   - Each cycle writes DEFAULT_WORD to mem[cnt], then cnt++.
//   - After writing cnt=DEPTH-1, next state is READY.
//   - INIT lasts exactly DEPTH cycles after reset_n deasserts.
//   - rd_en and wr_en are ignored in INIT (no valid, no err, no write).
//  FSM READY:
//   - Terminal state; only reset returns to INIT.
//   - init_busy=0, rd_ready=1.
//  Read:
//   - A request accepted at edge N gives rd_valid=1 and rd_data valid after edge N+READ_LAT-1+1.
//   - READ_LAT=1: data is visible in the cycle after the request.
//   - Reads are fully pipelined: one request per cycle, no bubbles, in order.
//   - rd_valid=0 in any cycle with no matching accepted request; rd_data then holds its last value.
//   - rd_addr >= DEPTH returns DEFAULT_WORD; compare on the full ADDR_W value, no aliasing/wrap.
//  Write:
//   - Committed at the accepting edge when wr_addr < DEPTH.
//   - Otherwise discarded, and wr_err=1 for the following cycle only.
//  Simultaneous rd and wr to the same address in the same cycle: read-first, returning the OLD word.
//   The new word is returned by any read accepted on a later cycle.
//  Back-to-back writes to the same address: last write wins.
//  The memory array is not reset other than by the INIT fill.
//  No combinational path from inputs to outputs.
// TESTING
//  1. Reset, DEPTH=64 -> init_busy high exactly 64 cycles, then rd_ready=1.
//     Read addrs 0..63 -> all 32'hD60003E0.
//  2. Write 0x910193E4 @0 and 0xD2803208 @1, then read 0,1 back-to-back.
//     -> valid on consecutive cycles, correct data, latency = READ_LAT (check 1 and 2).
//  3. Read addr 64 and 16'hFFFF -> DEFAULT_WORD.
//     Write addr 64 -> wr_err pulses 1 cycle; mem[0] unchanged.
//  4. Same cycle: wr_en @5=0x12345678 and rd_en @5 -> old value (DEFAULT_WORD).
//     Next-cycle read @5 -> 0x12345678.
//  5. Assert reset_n=0 mid read stream with writes pending -> rd_valid drops immediately.
//     After release: full INIT again; @0 reads DEFAULT_WORD.
//  6. rd_en/wr_en driven during INIT -> no rd_valid, no wr_err, contents remain DEFAULT_WORD.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous, writable LEGv8 instruction memory with a pipelined fetch port.
// After reset it fills every word with DEFAULT_WORD before it accepts any request.
module instr_mem_sync #(
    parameter int unsigned         DATA_W       = 32,
    parameter int unsigned         ADDR_W       = 16,
    parameter int unsigned         DEPTH        = 64,
    parameter logic [DATA_W-1:0]   DEFAULT_WORD = DATA_W'(32'hD60003E0),
    parameter int unsigned         READ_LAT     = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic              init_busy
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_acc;
    logic              wr_acc;
    logic              rd_hit;
    logic              wr_hit;
    logic [DATA_W-1:0] rd_word;

    // State and fill-counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // INIT walks the whole array once, then READY is terminal
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_INIT) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DEPTH - 1)) begin
                state_nxt = ST_READY;
                cnt_nxt   = '0;
            end
        end
    end

    assign rd_ready  = (state == ST_READY);
    assign init_busy = (state == ST_INIT);

    // Range checks use the full address so out-of-range indices never alias
    assign rd_acc  = rd_en & (state == ST_READY);
    assign wr_acc  = wr_en & (state == ST_READY);
    assign rd_hit  = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign wr_hit  = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_word = rd_hit ? mem[rd_addr[CNT_W-1:0]] : DEFAULT_WORD;

    // Array has no reset; the INIT fill is its only initialisation
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            mem[cnt] <= DEFAULT_WORD;
        end else if (wr_acc && wr_hit) begin
            mem[wr_addr[CNT_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_acc & ~wr_hit;
        end
    end

    // Array is sampled at the accepting edge, so a same-cycle write is seen only by later reads
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd_valid <= 1'b0;
                rd_data  <= DEFAULT_WORD;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic              s1_valid;
        logic [DATA_W-1:0] s1_data;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s1_valid <= 1'b0;
                s1_data  <= DEFAULT_WORD;
                rd_valid <= 1'b0;
                rd_data  <= DEFAULT_WORD;
            end else begin
                s1_valid <= rd_acc;
                if (rd_acc) begin
                    s1_data <= rd_word;
                end
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    rd_data <= s1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync; drives READ_LAT=1 and READ_LAT=2 instances in lockstep.
module tb_instr_mem_sync;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] DEF   = 32'hD60003E0;

    typedef struct {
        logic [31:0] data;
        int          stamp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] rd_addr;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    logic        rdy   [2];
    logic        busy  [2];
    logic        valid [2];
    logic        err   [2];
    logic [31:0] data  [2];

    exp_t        q [2][$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_exp [2];
    int          ncyc;
    int          init_left;
    int          err_due;
    int          busy_cnt;
    int          n_checks;
    int          n_err;

    always #5 clock = ~clock;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        instr_mem_sync #(
            .DATA_W       (32),
            .ADDR_W       (16),
            .DEPTH        (DEPTH),
            .DEFAULT_WORD (DEF),
            .READ_LAT     (k + 1)
        ) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .rd_en     (rd_en),
            .rd_addr   (rd_addr),
            .rd_ready  (rdy[k]),
            .rd_valid  (valid[k]),
            .rd_data   (data[k]),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .wr_err    (err[k]),
            .init_busy (busy[k])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Sample outputs on the falling edge, then predict what the next rising edge accepts
    always @(negedge clock) begin
        exp_t        e;
        logic [31:0] ev;
        ncyc++;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("rst_valid%0d", k), 32'(valid[k]), 32'(0));
                check_eq($sformatf("rst_data%0d", k), data[k], DEF);
                check_eq($sformatf("rst_err%0d", k), 32'(err[k]), 32'(0));
                check_eq($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'(1));
                check_eq($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'(0));
                q[k].delete();
                last_exp[k] = DEF;
            end
            for (int i = 0; i < int'(DEPTH); i++) model[i] = DEF;
            init_left = DEPTH;
            err_due   = -1;
            busy_cnt  = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("busy%0d", k), 32'(busy[k]), 32'(init_left > 0));
                check_eq($sformatf("ready%0d", k), 32'(rdy[k]), 32'(init_left == 0));
                check_eq($sformatf("wr_err%0d", k), 32'(err[k]), 32'(ncyc == err_due));
                if (valid[k]) begin
                    if (q[k].size() == 0) begin
                        check_eq($sformatf("spurious_valid%0d", k), 32'(valid[k]), 32'(0));
                    end else begin
                        e = q[k].pop_front();
                        check_eq($sformatf("rd_data%0d", k), data[k], e.data);
                        check_eq($sformatf("latency%0d", k), 32'(ncyc - e.stamp), 32'(k + 1));
                        last_exp[k] = e.data;
                    end
                end else begin
                    check_eq($sformatf("hold%0d", k), data[k], last_exp[k]);
                end
            end
            if (busy[0]) busy_cnt++;
            if (init_left > 0) begin
                init_left--;
            end else begin
                if (rd_en) begin
                    ev = (rd_addr < 16'(DEPTH)) ? model[rd_addr[5:0]] : DEF;
                    for (int k = 0; k < 2; k++) q[k].push_back('{data: ev, stamp: ncyc});
                end
                if (wr_en) begin
                    if (wr_addr < 16'(DEPTH)) model[wr_addr[5:0]] = wr_data;
                    else err_due = ncyc + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic rd(input logic [15:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        ncyc     = 0;
        n_checks = 0;
        n_err    = 0;
        init_left = DEPTH;
        err_due  = -1;
        busy_cnt = 0;
        for (int k = 0; k < 2; k++) last_exp[k] = DEF;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = DEF;

        repeat (3) step();
        reset_n = 1'b1;
        idle(DEPTH + 2);
        check_eq("init_cycles", 32'(busy_cnt), 32'(DEPTH));

        // Whole array reads back the fill word
        for (int i = 0; i < int'(DEPTH); i++) rd(16'(i));
        idle(3);

        wr(16'd0, 32'h910193E4);
        wr(16'd1, 32'hD2803208);
        rd(16'd0);
        rd(16'd1);
        idle(3);

        // Out-of-range reads and writes
        rd(16'd64);
        rd(16'hFFFF);
        wr(16'd64, 32'hDEADBEEF);
        idle(1);
        wr(16'hFFFF, 32'hCAFEF00D);
        rd(16'd0);
        idle(3);

        // Same-cycle read and write to one address returns the old word
        rd_en   = 1'b1;
        rd_addr = 16'd5;
        wr_en   = 1'b1;
        wr_addr = 16'd5;
        wr_data = 32'h12345678;
        step();
        wr_en = 1'b0;
        rd(16'd5);
        idle(3);

        wr(16'd7, 32'hAAAA0001);
        wr(16'd7, 32'hBBBB0002);
        rd(16'd7);
        rd(16'd63);
        idle(3);

        // Reset in the middle of a read stream with writes in flight
        for (int i = 0; i < 10; i++) begin
            rd_en   = 1'b1;
            rd_addr = 16'(i);
            wr_en   = 1'b1;
            wr_addr = 16'(i + 10);
            wr_data = $urandom;
            step();
        end
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Requests during INIT must be ignored
        for (int i = 0; i < 30; i++) begin
            rd_en   = 1'b1;
            rd_addr = 16'(i);
            wr_en   = 1'b1;
            wr_addr = (i % 2 == 0) ? 16'd3 : 16'd64;
            wr_data = $urandom;
            step();
        end
        idle(DEPTH);
        check_eq("reinit_cycles", 32'(busy_cnt), 32'(DEPTH));
        rd(16'd0);
        rd(16'd3);
        rd(16'd5);
        rd(16'd12);
        idle(4);

        check_eq("q_empty0", 32'(q[0].size()), 32'(0));
        check_eq("q_empty1", 32'(q[1].size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
